// File: rtl/dmem_lsu.sv
// dmem_lsu: RISC-V B/H/W load/store unit over a word-only data memory (SB/SH via read-modify-write)
// Ports: clk/rst (sync, active-high); core side req_valid/req_ready/req_we/req_funct3/req_addr/req_wdata,
//   resp_valid/resp_rdata/resp_err; memory side MemRead/MemWrite/addr/WriteData/ReadData (combinational read).
// Define DMEM_LSU_ALIGN_CHECK_EN to turn misaligned H/HU/W accesses into error responses.
module dmem_lsu #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic              MemRead,
  output logic              MemWrite,
  output logic [ADDR_W-1:0] addr,
  output logic [31:0]       WriteData,
  input  logic [31:0]       ReadData
);
  typedef enum logic [2:0] {IDLE, RD, RMW_RD, WR, RESP} state_t;
  state_t state_q, state_d;
  logic we_q, we_d, err_q, err_d, bad;
  logic [2:0] f3_q, f3_d;
  logic [ADDR_W-1:0] a_q, a_d;
  logic [31:0] wd_q, wd_d, rdata_q, rdata_d, sh, ld_ext, mask, ins, merged;
  logic [15:0] half;
  always_comb begin
    bad = (req_funct3 == 3'b011) | (req_funct3[2:1] == 2'b11) | (req_funct3[2] & req_we);
`ifdef DMEM_LSU_ALIGN_CHECK_EN
    bad = bad | ((req_funct3[1:0] == 2'b01) & req_addr[0]) | ((req_funct3[1:0] == 2'b10) & (|req_addr[1:0]));
`else
    bad = bad | 1'b0;
`endif
  end
  // Lane extraction for loads; sign extension suppressed for BU/HU (funct3[2]).
  assign sh     = ReadData >> {a_q[1:0], 3'b000};
  assign half   = a_q[1] ? ReadData[31:16] : ReadData[15:0];
  assign ld_ext = (f3_q[1:0] == 2'b00) ? {{24{~f3_q[2] & sh[7]}}, sh[7:0]} :
                  (f3_q[1:0] == 2'b01) ? {{16{~f3_q[2] & half[15]}}, half} : ReadData;
  // Store merge: replicate the store data across lanes and keep only the addressed lane.
  assign mask   = f3_q[0] ? (a_q[1] ? 32'hFFFF_0000 : 32'h0000_FFFF) : (32'h0000_00FF << {a_q[1:0], 3'b000});
  assign ins    = f3_q[0] ? {2{wd_q[15:0]}} : {4{wd_q[7:0]}};
  assign merged = (ReadData & ~mask) | (ins & mask);
  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    f3_d    = f3_q;
    a_d     = a_q;
    wd_d    = wd_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      IDLE: if (req_valid) begin
        we_d    = req_we;
        f3_d    = req_funct3;
        a_d     = req_addr;
        wd_d    = req_wdata;
        rdata_d = '0;
        err_d   = bad;
        state_d = bad ? RESP : !req_we ? RD : req_funct3[1] ? WR : RMW_RD;
      end
      RD: begin
        rdata_d = ld_ext;
        state_d = RESP;
      end
      RMW_RD: begin
        wd_d    = merged;
        state_d = WR;
      end
      WR:      state_d = RESP;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      we_q    <= 1'b0;
      f3_q    <= '0;
      a_q     <= '0;
      wd_q    <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      f3_q    <= f3_d;
      a_q     <= a_d;
      wd_q    <= wd_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end
  assign req_ready  = state_q == IDLE;
  assign resp_valid = state_q == RESP;
  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;
  assign MemRead    = (state_q == RD) | (state_q == RMW_RD);
  assign MemWrite   = state_q == WR;
  assign addr       = (MemRead | MemWrite) ? {a_q[ADDR_W-1:2], 2'b00} : '0;
  assign WriteData  = MemWrite ? wd_q : '0;
endmodule

// File: tb/tb_dmem_lsu.sv
// tb_dmem_lsu: directed self-checking bench for dmem_lsu with a small word memory model
module tb_dmem_lsu;
  logic clk = 0, rst = 1, req_valid = 0, req_we = 0;
  logic [2:0] req_funct3 = 0;
  logic [31:0] req_addr = 0, req_wdata = 0;
  logic req_ready, resp_valid, resp_err, MemRead, MemWrite;
  logic [31:0] resp_rdata, addr, WriteData, ReadData;
  logic [31:0] mem [16];
  int rd_tot = 0, wr_tot = 0, both = 0;
  logic [31:0] wr_last = 0, wa_last = 0;
  int vecs = 0, errs = 0;

  dmem_lsu #(.ADDR_W(32)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .MemRead(MemRead), .MemWrite(MemWrite), .addr(addr), .WriteData(WriteData), .ReadData(ReadData)
  );

  always #5 clk = ~clk;
  assign ReadData = mem[addr[5:2]];

  always @(posedge clk) begin
    if (MemRead) rd_tot <= rd_tot + 1;
    if (MemRead && MemWrite) both <= both + 1;
    if (MemWrite) begin
      wr_tot <= wr_tot + 1;
      wr_last <= WriteData;
      wa_last <= addr;
      mem[addr[5:2]] <= WriteData;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  int lat, rd0, wr0;
  task automatic req(input logic we, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
    @(negedge clk);
    req_valid = 1; req_we = we; req_funct3 = f3; req_addr = a; req_wdata = wd;
    rd0 = rd_tot; wr0 = wr_tot; lat = 0;
    do begin
      @(posedge clk); lat++;
      @(negedge clk); req_valid = 0;
    end while (!resp_valid && lat < 10);
  endtask

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", {31'b0, req_ready}, 1);
    chk("rst_rvalid", {31'b0, resp_valid}, 0);
    chk("rst_mem", {30'b0, MemRead, MemWrite}, 0);
    chk("rst_rdata", resp_rdata, 0);
    chk("rst_err", {31'b0, resp_err}, 0);
    rst = 0;

    req(1, 3'b010, 32'h10, 32'hDEADBEEF);
    chk("sw_lat", lat, 2);
    chk("sw_wr", wr_tot - wr0, 1);
    chk("sw_rd", rd_tot - rd0, 0);
    chk("sw_wdata", wr_last, 32'hDEADBEEF);
    chk("sw_waddr", wa_last, 32'h10);
    chk("sw_err", {31'b0, resp_err}, 0);
    @(negedge clk);
    chk("sw_pulse", {30'b0, resp_valid, req_ready}, 1);

    req(1, 3'b000, 32'h11, 32'h000000A5);
    chk("sb_lat", lat, 3);
    chk("sb_rd", rd_tot - rd0, 1);
    chk("sb_wr", wr_tot - wr0, 1);
    chk("sb_wdata", wr_last, 32'hDEADA5EF);

    req(0, 3'b000, 32'h11, 0);
    chk("lb_lat", lat, 2);
    chk("lb", resp_rdata, 32'hFFFFFFA5);
    chk("lb_err", {31'b0, resp_err}, 0);
    req(0, 3'b100, 32'h11, 0);
    chk("lbu", resp_rdata, 32'h000000A5);
    req(0, 3'b001, 32'h12, 0);
    chk("lh", resp_rdata, 32'hFFFFDEAD);
    req(0, 3'b101, 32'h12, 0);
    chk("lhu", resp_rdata, 32'h0000DEAD);
    req(0, 3'b010, 32'h10, 0);
    chk("lw_lat", lat, 2);
    chk("lw", resp_rdata, 32'hDEADA5EF);
    req(0, 3'b000, 32'h10, 0);
    chk("lb0", resp_rdata, 32'hFFFFFFEF);
    req(0, 3'b100, 32'h13, 0);
    chk("lbu3", resp_rdata, 32'h000000DE);

    req(1, 3'b001, 32'h12, 32'hFFFF1234);
    chk("sh_lat", lat, 3);
    chk("sh_wdata", wr_last, 32'h1234A5EF);
    req(0, 3'b010, 32'h10, 0);
    chk("lw_after_sh", resp_rdata, 32'h1234A5EF);
    req(0, 3'b001, 32'h10, 0);
    chk("lh_low", resp_rdata, 32'hFFFFA5EF);

    req(0, 3'b010, 32'h13, 0);
`ifdef DMEM_LSU_ALIGN_CHECK_EN
    chk("mis_err", {31'b0, resp_err}, 1);
    chk("mis_rdata", resp_rdata, 0);
    chk("mis_lat", lat, 1);
    chk("mis_rd", rd_tot - rd0, 0);
`else
    chk("mis_err", {31'b0, resp_err}, 0);
    chk("mis_rdata", resp_rdata, 32'h1234A5EF);
    chk("mis_lat", lat, 2);
    chk("mis_rd", rd_tot - rd0, 1);
`endif

    req(0, 3'b011, 32'h10, 0);
    chk("ill_err", {31'b0, resp_err}, 1);
    chk("ill_rdata", resp_rdata, 0);
    chk("ill_lat", lat, 1);
    chk("ill_mem", (rd_tot - rd0) + (wr_tot - wr0), 0);
    req(1, 3'b100, 32'h10, 32'h55);
    chk("ill_st_err", {31'b0, resp_err}, 1);
    chk("ill_st_wr", wr_tot - wr0, 0);
    req(0, 3'b000, 32'h11, 0);
    chk("err_clear", {31'b0, resp_err}, 0);

    @(negedge clk);
    req_valid = 1; req_we = 1; req_funct3 = 3'b000; req_addr = 32'h11; req_wdata = 32'h77;
    wr0 = wr_tot;
    @(posedge clk);
    @(negedge clk);
    req_valid = 0;
    chk("rmw_state", {30'b0, MemRead, MemWrite}, 2);
    rst = 1;
    @(posedge clk);
    @(negedge clk);
    rst = 0;
    chk("rr_ready", {31'b0, req_ready}, 1);
    chk("rr_rvalid", {31'b0, resp_valid}, 0);
    chk("rr_wr", {31'b0, MemWrite}, 0);
    repeat (3) begin
      @(negedge clk);
      chk("rr_idle", {29'b0, resp_valid, MemWrite, req_ready}, 1);
    end
    chk("rr_nowrite", wr_tot - wr0, 0);
    req(0, 3'b010, 32'h10, 0);
    chk("rr_lw", resp_rdata, 32'h1234A5EF);

    chk("no_overlap", both, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule

// File: doc/dmem_lsu.md
# dmem_lsu

Load/store unit that issues MemRead/MemWrite/addr/WriteData to the word-organised data memory and consumes its combinational ReadData. Sits between the core's execute stage and the data memory. Performs RISC-V byte/halfword/word loads with sign/zero extension and implements SB/SH as read-modify-write, because the data memory only writes full words. One request in flight; valid/ready handshake toward the core.

## Interface
- ADDR_W, 32, byte-address width of core and memory address.
- clk  in  1  clock; all state changes on rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  unit can accept; high only in IDLE.
- req_we  in  1  1 = store, 0 = load.
- req_funct3  in  3  RISC-V funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU (BU/HU loads only).
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  32  store data; byte/half taken from LSBs.
- resp_valid  out  1  one-cycle completion pulse.
- resp_rdata  out  32  extended load result; 0 for stores/errors.
- resp_err  out  1  valid with resp_valid; misaligned or illegal request.
- MemRead  out  1  memory read enable.
- MemWrite  out  1  memory write enable (memory writes on next rising edge).
- addr  out  ADDR_W  word-aligned address, addr[1:0] = 00.
- WriteData  out  32  full word to write.
- ReadData  in  32  combinational memory read data, valid while MemRead = 1.

## Operation
- States: IDLE, RD, RMW_RD, WR, RESP.
- IDLE: req_ready = 1. On req_valid, latch we/funct3/addr/wdata, then:
  - illegal funct3 (011, 110, 111; or 1xx with req_we = 1) or misaligned (see Configuration) -> RESP with err = 1; no memory access.
  - load -> RD; SW -> WR; SB/SH -> RMW_RD.
- RD: MemRead = 1, addr = {a[ADDR_W-1:2], 2'b00}. At edge, select lane by a[1:0] (byte) or a[1] (half); sign-extend for B/H, zero-extend for BU/HU; register into resp_rdata -> RESP.
- RMW_RD: MemRead = 1, same addr. At edge, merge wdata into captured word: SB replaces byte a[1:0]; SH replaces half a[1]; other bytes kept -> WR.
- WR: MemWrite = 1, WriteData = merged word (SB/SH) or wdata (SW) -> RESP.
- RESP: resp_valid = 1 for exactly one cycle -> IDLE. A new request is never accepted in RESP.
- MemRead and MemWrite are never high together; both are 0 in IDLE and RESP.
- Reset (any state): next cycle state = IDLE; all outputs 0 except req_ready = 1. In-flight request discarded, no resp_valid, no MemWrite. Asserting rst in WR still lets the memory perform that cycle's write; asserting it in RMW_RD prevents the write.

## Timing
- Request accepted at edge T0 (req_valid & req_ready).
- Load: RD in T0–T1; resp_valid in the cycle after T1 edge. Latency 2 cycles.
- SW: WR, then RESP. Latency 2. Memory updated at the edge ending WR.
- SB/SH: RMW_RD, WR, RESP. Latency 3.
- Error: RESP immediately. Latency 1.
- resp_rdata and resp_err are held from entering RESP until the next response; the value only matters while resp_valid = 1.
- Throughput: 1 request per 3 (load/SW) or 4 (SB/SH) cycles.

## Configuration
- DMEM_LSU_ALIGN_CHECK_EN defined: H/HU with a[0] = 1, or W with a[1:0] != 00, produce an error response; no MemRead/MemWrite.
- Undefined: no alignment check. The half lane comes from a[1] only and word accesses ignore a[1:0]. resp_err is set only for illegal funct3.

## Test plan
- SW addr 0x10 wdata 0xDEADBEEF -> single MemWrite pulse with addr 0x10, WriteData 0xDEADBEEF; resp_valid 2 cycles after accept, err = 0.
- Then SB addr 0x11 wdata 0x000000A5 -> MemRead then MemWrite cycles, WriteData 0xDEADA5EF; latency 3.
- Then LB 0x11 -> 0xFFFFFFA5; LBU 0x11 -> 0x000000A5; LH 0x12 -> 0xFFFFDEAD; LHU 0x12 -> 0x0000DEAD; LW 0x10 -> 0xDEADA5EF; each latency 2.
- SH 0x12 wdata 0x00001234 -> word at 0x10 becomes 0x1234A5EF. With DMEM_LSU_ALIGN_CHECK_EN, LW 0x13 -> resp_err = 1, resp_rdata = 0, latency 1, MemRead never asserted.
- Illegal funct3 011 load -> resp_err = 1, no memory access (both macro settings).
- SB 0x11 with rst pulsed during RMW_RD -> no MemWrite, no resp_valid, req_ready = 1 the cycle after reset; a subsequent LW 0x10 returns the unchanged word.
